// File: rtl/hwrng_arbiter.sv
// hwrng_arbiter: samples a free-running 32-bit entropy word at a fixed rate,
// rejects repeated values (flagging a stuck source), buffers accepted words
// in a small FIFO and hands them out one word per grant, round-robin.
module hwrng_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int FIFO_DEPTH  = 4,
   parameter int SAMPLE_DIV  = 16,
   parameter int STUCK_LIMIT = 8
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [31:0]                       rng_in,
   input  logic [NUM_REQ-1:0]                req,
   output logic [NUM_REQ-1:0]                ack,
   output logic [31:0]                       rand_out,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
   output logic                              fault
);

   localparam int LW = $clog2(FIFO_DEPTH+1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = $clog2(NUM_REQ);
   localparam int DW = $clog2(SAMPLE_DIV);
   localparam int CW = $clog2(STUCK_LIMIT+1);

   // ---------------------------------------------------------------------
   // Sampler state
   // ---------------------------------------------------------------------
   logic [DW-1:0]      r_div;
   logic [31:0]        r_last;
   logic [CW-1:0]      r_dup;
   logic               r_fault;

   // ---------------------------------------------------------------------
   // FIFO state
   // ---------------------------------------------------------------------
   logic [31:0]        r_mem [FIFO_DEPTH];
   logic [AW-1:0]      r_wr;
   logic [AW-1:0]      r_rd;
   logic [LW-1:0]      r_level;

   // ---------------------------------------------------------------------
   // Arbiter state
   // ---------------------------------------------------------------------
   logic [NUM_REQ-1:0] r_ack;
   logic [31:0]        r_rand;
   logic [PW-1:0]      r_ptr;

   // ---------------------------------------------------------------------
   // Combinational signals
   // ---------------------------------------------------------------------
   logic               w_strobe;
   logic               w_dup;
   logic               w_push;
   logic               w_pop;
   logic [NUM_REQ-1:0] w_elig;
   logic               w_gnt_vld;
   logic [PW-1:0]      w_gnt_idx;
   logic [NUM_REQ-1:0] w_gnt_oh;
   logic [PW-1:0]      w_ptr_nxt;

   // Strobe in the last cycle of each divider period.
   assign w_strobe = (r_div == DW'(SAMPLE_DIV-1));

   // A first sample of zero after reset matches the cleared last_sample and
   // is therefore treated as a duplicate, which is intended.
   assign w_dup    = (rng_in == r_last);

   // Pushes are blocked once the source is flagged stuck; a full FIFO drops
   // the word but still accepts it as the new last_sample.
   assign w_push   = w_strobe & ~w_dup & ~r_fault & (r_level < LW'(FIFO_DEPTH));

   // Mask the requester acked this cycle so it cannot be re-granted before
   // it has had a chance to drop req.
   assign w_elig   = req & ~r_ack;

   // Grant only from words already registered in the FIFO, so a word pushed
   // into an empty FIFO becomes poppable one cycle later.
   assign w_pop    = w_gnt_vld & (r_level != '0);

   assign w_gnt_oh  = NUM_REQ'(1) << w_gnt_idx;
   assign w_ptr_nxt = (w_gnt_idx == PW'(NUM_REQ-1)) ? '0 : w_gnt_idx + PW'(1);

   // Sample divider: free-running 0..SAMPLE_DIV-1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_div <= '0;
      end else if (w_strobe) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + DW'(1);
      end
   end

   // Duplicate detection and sticky stuck-source flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last  <= '0;
         r_dup   <= '0;
         r_fault <= 1'b0;
      end else if (w_strobe) begin
         if (w_dup) begin
            if (r_dup != CW'(STUCK_LIMIT))
               r_dup <= r_dup + CW'(1);
            // Fault rises on the same edge that the count reaches the limit.
            if (r_dup >= CW'(STUCK_LIMIT-1))
               r_fault <= 1'b1;
         end else begin
            r_dup  <= '0;
            r_last <= rng_in;
         end
      end
   end

   // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
   always_comb begin : p_arb
      int v_idx;
      v_idx     = 0;
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         v_idx = int'(r_ptr) + i;
         if (v_idx >= NUM_REQ)
            v_idx = v_idx - NUM_REQ;
         if (!w_gnt_vld && w_elig[v_idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = PW'(v_idx);
         end
      end
   end

   // FIFO storage; contents need no reset since pointers and level do.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr] <= rng_in;
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave level as is.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else begin
         if (w_push)
            r_wr <= r_wr + AW'(1);
         if (w_pop)
            r_rd <= r_rd + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Registered grant: one-cycle ack pulse, popped word, advanced pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ack  <= '0;
         r_rand <= '0;
         r_ptr  <= '0;
      end else begin
         r_ack <= w_pop ? w_gnt_oh : '0;
         if (w_pop) begin
            r_rand <= r_mem[r_rd];
            r_ptr  <= w_ptr_nxt;
         end
      end
   end

   assign ack      = r_ack;
   assign rand_out = r_rand;
   assign level    = r_level;
   assign fault    = r_fault;

endmodule

// File: tb/tb_hwrng_arbiter.sv
// tb_hwrng_arbiter: directed vectors for hwrng_arbiter with default parameters.
// Edges are counted from reset release; after edge k the bench drives
// rng_in = k + 1 + rng_off while the ramp is enabled, so the word accepted at
// strobe edge 16*n is 16*n + rng_off.
module tb_hwrng_arbiter;

   logic        clk;
   logic        reset_n;
   logic [31:0] rng_in;
   logic [3:0]  req;
   logic [3:0]  ack;
   logic [31:0] rand_out;
   logic [2:0]  level;
   logic        fault;

   int n_chk;
   int n_fail;
   int cyc;
   int rng_off;
   bit rng_run;

   hwrng_arbiter #(
      .NUM_REQ     (4),
      .FIFO_DEPTH  (4),
      .SAMPLE_DIV  (16),
      .STUCK_LIMIT (8)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .rng_in   (rng_in),
      .req      (req),
      .ack      (ack),
      .rand_out (rand_out),
      .level    (level),
      .fault    (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h (edge %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (rng_run)
         rng_in = 32'(cyc + 1 + rng_off);
   endtask

   task automatic run_to(input int k);
      while (cyc < k)
         tick();
   endtask

   task automatic release_reset(input int off);
      reset_n = 1'b1;
      cyc     = 0;
      rng_off = off;
      rng_run = 1'b1;
      rng_in  = 32'(1 + off);
      req     = '0;
   endtask

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      cyc     = 0;
      rng_off = 0;
      rng_run = 1'b0;
      rng_in  = '0;
      req     = '0;
      reset_n = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("rst_ack",   32'(ack), 32'h0);
      chk("rst_rand",  rand_out, 32'h0);
      chk("rst_level", 32'(level), 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      release_reset(0);

      // Fill from reset: pushes at 16,32,48,64; fifth word dropped.
      run_to(15); chk("fill_l15", 32'(level), 32'd0);
      run_to(16); chk("fill_l16", 32'(level), 32'd1);
      run_to(32); chk("fill_l32", 32'(level), 32'd2);
      run_to(48); chk("fill_l48", 32'(level), 32'd3);
      run_to(64); chk("fill_l64", 32'(level), 32'd4);
      run_to(80); chk("fill_l80", 32'(level), 32'd4);
      chk("fill_fault", 32'(fault), 32'h0);
      chk("fill_ack",   32'(ack),   32'h0);

      // Round-robin over a full FIFO holding 16,32,48,64.
      run_to(81); req = 4'b1111;
      run_to(82); chk("rr_ack0", 32'(ack), 32'h1); chk("rr_rand0", rand_out, 32'd16);
      chk("rr_lvl0", 32'(level), 32'd3);
      run_to(83); chk("rr_ack1", 32'(ack), 32'h2); chk("rr_rand1", rand_out, 32'd32);
      req = 4'b1110;
      run_to(84); chk("rr_ack2", 32'(ack), 32'h4); chk("rr_rand2", rand_out, 32'd48);
      req = 4'b1100;
      run_to(85); chk("rr_ack3", 32'(ack), 32'h8); chk("rr_rand3", rand_out, 32'd64);
      req = 4'b1000;
      run_to(86); chk("rr_ack4", 32'(ack), 32'h0); chk("rr_rand4", rand_out, 32'd64);
      chk("rr_lvl4", 32'(level), 32'd0);
      req = 4'b0000;

      // No back-to-back re-grant: req[2] held, FIFO holds 96 and 112.
      run_to(112); chk("b2b_lvl", 32'(level), 32'd2);
      req = 4'b0100;
      run_to(113); chk("b2b_ack113", 32'(ack), 32'h4); chk("b2b_rand113", rand_out, 32'd96);
      run_to(114); chk("b2b_ack114", 32'(ack), 32'h0); chk("b2b_rand114", rand_out, 32'd96);
      run_to(115); chk("b2b_ack115", 32'(ack), 32'h4); chk("b2b_rand115", rand_out, 32'd112);
      run_to(116); chk("b2b_ack116", 32'(ack), 32'h0);
      run_to(117); chk("b2b_ack117", 32'(ack), 32'h0); chk("b2b_lvl117", 32'(level), 32'd0);
      run_to(120); chk("b2b_ack120", 32'(ack), 32'h0);
      req = 4'b0000;

      // Grant coincides with a push at level 1: level stays, old head out.
      run_to(128); chk("sim_lvl128", 32'(level), 32'd1);
      run_to(143); req = 4'b0001;
      run_to(144); chk("sim_ack144", 32'(ack), 32'h1); chk("sim_rand144", rand_out, 32'd128);
      chk("sim_lvl144", 32'(level), 32'd1);
      run_to(145); chk("sim_ack145", 32'(ack), 32'h0); chk("sim_lvl145", 32'(level), 32'd1);
      req = 4'b0010;
      run_to(146); chk("sim_ack146", 32'(ack), 32'h2); chk("sim_rand146", rand_out, 32'd144);
      run_to(147); req = 4'b0000;
      // Push into an empty FIFO while req[3] waits: ack one cycle later.
      run_to(158); req = 4'b1000;
      run_to(159); chk("emp_ack159", 32'(ack), 32'h0);
      run_to(160); chk("emp_ack160", 32'(ack), 32'h0); chk("emp_lvl160", 32'(level), 32'd1);
      run_to(161); chk("emp_ack161", 32'(ack), 32'h8); chk("emp_rand161", rand_out, 32'd160);
      chk("emp_lvl161", 32'(level), 32'd0);
      run_to(162); req = 4'b0000;

      // Stuck source: one accepted push of 5A5A5A5A, then 8 duplicate strobes.
      run_to(175); rng_run = 1'b0; rng_in = 32'h5A5A5A5A;
      run_to(176); chk("stk_lvl176", 32'(level), 32'd1); chk("stk_f176", 32'(fault), 32'h0);
      run_to(288); chk("stk_f288", 32'(fault), 32'h0);
      run_to(304); chk("stk_f304", 32'(fault), 32'h1); chk("stk_lvl304", 32'(level), 32'd1);
      run_to(305); req = 4'b0100;
      run_to(306); chk("stk_ack306", 32'(ack), 32'h4); chk("stk_rand306", rand_out, 32'h5A5A5A5A);
      run_to(307); req = 4'b0000; rng_in = 32'h12340000;
      run_to(330); req = 4'b0001;
      run_to(336); chk("stk_lvl336", 32'(level), 32'd0);
      run_to(337); chk("stk_ack337", 32'(ack), 32'h0);
      run_to(340); chk("stk_ack340", 32'(ack), 32'h0); chk("stk_f340", 32'(fault), 32'h1);
      req = 4'b0000;

      // Reset clears the fault; refill three words, then reset during an ack.
      reset_n = 1'b0;
      tick(); tick();
      release_reset(0);
      chk("rst2_fault", 32'(fault), 32'h0);
      run_to(63); req = 4'b0001;
      run_to(64); chk("mid_ack64", 32'(ack), 32'h1); chk("mid_rand64", rand_out, 32'd16);
      chk("mid_lvl64", 32'(level), 32'd3);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_ack",   32'(ack), 32'h0);
      chk("mid_rst_rand",  rand_out, 32'h0);
      chk("mid_rst_level", 32'(level), 32'h0);
      chk("mid_rst_fault", 32'(fault), 32'h0);
      @(posedge clk);
      #1;
      release_reset(1000);
      run_to(15); chk("post_l15", 32'(level), 32'd0);
      run_to(16); chk("post_l16", 32'(level), 32'd1);
      req = 4'b0010;
      run_to(17); chk("post_ack17", 32'(ack), 32'h2); chk("post_rand17", rand_out, 32'd1016);
      chk("post_l17", 32'(level), 32'd0);
      req = 4'b0000;

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
